fifo_ctrl: RTL and testbench

Pointer and flow-control sequencer for a dual-ported RAM used as a FIFO: it accepts words on a valid/ready input stream, writes them into the RAM, and presents the oldest stored word on a valid/ready output stream. It owns the write/read addresses, occupancy count and full/empty status; the RAM stays storage-only (synchronous write, combinational read). It sits between a producer and consumer stage in the dataflow path, instantiated once per FIFO, alongside `ram_dual_ported`.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 16 +
 rtl/fifo_ctrl.sv | 60 ++++++
 tb/tb_fifo_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers and the status bundle shared by the FIFO controller.
package fifo_pkg;
  localparam int CNT_MAX_W = 16;
  typedef struct packed {
    logic                 full;
    logic                 empty;
    logic [CNT_MAX_W-1:0] count;
  } fifo_status_t;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: RAM address pointer that wraps from DEPTH-1 to 0, with clear and increment.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  output logic [addr_w(DEPTH)-1:0]  ptr
);
  localparam int AW = addr_w(DEPTH);
  always_ff @(posedge clk)
    ptr <= (rst || clr) ? '0 : !inc ? ptr : (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flow-control sequencer for a RAM-backed FIFO; FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEPTH           = 4,
  parameter int ALMOST_FULL_TH  = DEPTH - 1,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      ram_write_en,
  output logic [addr_w(DEPTH)-1:0]  ram_write_address,
  output logic [WIDTH-1:0]          ram_din,
  output logic [addr_w(DEPTH)-1:0]  ram_read_address,
  input  logic [WIDTH-1:0]          ram_dout
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                      almost_full,
  output logic                      almost_empty
`endif
);
  localparam int CW = cnt_w(DEPTH);
  fifo_status_t status;
  logic push, pop;
  logic [CW-1:0] cnt_nxt;
  assign status    = '{full: count == CW'(DEPTH), empty: count == '0, count: CNT_MAX_W'(count)};
  assign in_ready  = !status.full;
  assign out_valid = !status.empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign ram_write_en = push;
  assign ram_din   = in_data;
  assign out_data  = ram_dout;
  // rst folds into the next-count so the almost flags reset consistently with count
  assign cnt_nxt   = (rst || flush) ? '0 :
                     CW'(status.count + CNT_MAX_W'(push) - CNT_MAX_W'(pop));
  always_ff @(posedge clk)
    count <= cnt_nxt;
`ifdef FIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk) begin
    almost_full  <= int'(cnt_nxt) >= ALMOST_FULL_TH;
    almost_empty <= int'(cnt_nxt) <= ALMOST_EMPTY_TH;
  end
`endif
  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .rst(rst), .clr(flush), .inc(push), .ptr(ram_write_address)
  );
  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .rst(rst), .clr(flush), .inc(pop), .ptr(ram_read_address)
  );
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed checks of fifo_ctrl (DEPTH=4) against a behavioural dual-ported RAM.
module tb_fifo_ctrl;
  logic       clk = 0;
  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, ram_write_en;
  logic [7:0] out_data, ram_din, ram_dout;
  logic [2:0] count;
  logic [1:0] ram_write_address, ram_read_address;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic almost_full, almost_empty;
`endif
  logic [7:0] mem [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_write_en) mem[ram_write_address] <= ram_din;
  assign ram_dout = mem[ram_read_address];

  fifo_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .ram_write_en(ram_write_en),
    .ram_write_address(ram_write_address), .ram_din(ram_din),
    .ram_read_address(ram_read_address), .ram_dout(ram_dout)
`ifdef FIFO_ALMOST_FLAGS_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; flush = 0; in_data = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick(); tick();
    rst = 0;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", ram_write_en); end
    checks++; if ({ram_write_address, ram_read_address} !== 4'h0) begin errors++; $display("FAIL reset_ptrs got %h/%h exp 0/0", ram_write_address, ram_read_address); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = v[i]; #1;
      checks++; if (ram_write_en !== 1'b1) begin errors++; $display("FAIL fill_wen%0d got %b exp 1", i, ram_write_en); end
      tick();
    end
    in_valid = 1; in_data = 8'h55; #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b exp 0", in_ready); end
    checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL fill_fifth_wen got %b exp 0", ram_write_en); end
    tick();
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL fill_stable got %h exp 11", out_data); end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_data !== v[i] || out_valid !== 1'b1) begin errors++; $display("FAIL drain%0d got %h/%b exp %h/1", i, out_data, out_valid, v[i]); end
      tick();
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got %b/%0d exp 0/0", out_valid, count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(3 + i); #1;
      checks++; if (out_data !== 8'(1 + i)) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, out_data, 8'(1 + i)); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d got %0d exp 2", i, count); end
    end
    checks++; if (ram_write_address !== 2'd0 || ram_read_address !== 2'd2) begin errors++; $display("FAIL b2b_ptrs got %0d/%0d exp 0/2", ram_write_address, ram_read_address); end
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (out_data !== 8'(7 + i)) begin errors++; $display("FAIL b2b_tail%0d got %h exp %h", i, out_data, 8'(7 + i)); end
      tick();
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
  endtask

  task automatic test_full_pop();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin in_data = 8'(8'hA0 + i); tick(); end
    in_data = 8'hB0; out_ready = 1; #1;
    checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL fullpop_wen got %b exp 0", ram_write_en); end
    checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL fullpop_data got %h exp a0", out_data); end
    tick();
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_count got %0d/%b exp 3/1", count, in_ready); end
    out_ready = 0; #1;
    checks++; if (ram_write_en !== 1'b1) begin errors++; $display("FAIL fullpop_next_wen got %b exp 1", ram_write_en); end
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill got %0d exp 4", count); end
    in_valid = 0;
  endtask

  task automatic test_flush();
    out_ready = 1; tick(); out_ready = 0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d exp 3", count); end
    flush = 1; in_valid = 1; in_data = 8'hCC; out_ready = 1; #1;
    checks++; if (ram_write_en !== 1'b0) begin errors++; $display("FAIL flush_wen got %b exp 0", ram_write_en); end
    tick();
    flush = 0; in_valid = 0; out_ready = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_state got %0d/%b exp 0/0", count, out_valid); end
    checks++; if ({ram_write_address, ram_read_address} !== 4'h0) begin errors++; $display("FAIL flush_ptrs got %h/%h exp 0/0", ram_write_address, ram_read_address); end
    in_valid = 1; in_data = 8'hA5; tick(); in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL flush_readback got %b/%h exp 1/a5", out_valid, out_data); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_mid_reset();
    in_valid = 1; in_data = 8'h5A; tick(); tick(); in_valid = 0;
    rst = 1; tick(); rst = 0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst got %0d/%b/%b exp 0/0/1", count, out_valid, in_ready); end
  endtask

`ifdef FIFO_ALMOST_FLAGS_EN
  task automatic test_almost();
    logic [1:0] exp [5] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 5; i++) begin
      checks++; if ({almost_full, almost_empty} !== exp[i]) begin errors++; $display("FAIL almost%0d got %b exp %b", i, {almost_full, almost_empty}, exp[i]); end
      in_valid = 1; in_data = 8'(i); tick();
    end
    in_valid = 0; flush = 1; tick(); flush = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_flush();
`ifdef FIFO_ALMOST_FLAGS_EN
    test_almost();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
